ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 16-bit system RAM between two requesters: the CPU (port A) and the video/VGA text-buffer engine (port B).
- Sits between both requesters and the RAM's address, data-in, data-out and rw pins, on the RAM clock domain.
- Sequences each access (address phase, write strobe or read-latency wait, data return) and grants access by fixed video priority plus a CPU starvation guard.

Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width
- RD_LAT, 1, RAM read latency in clocks from address-valid to data-valid (1..4)
- MAX_WAIT, 4, number of consecutive video grants a pending CPU request tolerates before it is forced (1..15)

Ports:
- clock  in  1  RAM-domain clock; all logic is rising-edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_rw  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
- vid_req, vid_rw, vid_addr, vid_wdata  in  1/1/ADDR_W/DATA_W  video request, same semantics as the CPU inputs
- vid_ack  out  1  video completion pulse
- vid_rdata  out  DATA_W  video read data
- ram_address  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM write data
- ram_rw  out  1  RAM write enable (1 = write)
- ram_data_out  in  DATA_W  from RAM read data
- busy  out  1  high in every state except IDLE
- grant_cpu  out  1  1 when the current or most recent grant belongs to the CPU

Behaviour:
- Reset: every output is 0, FSM = IDLE, wait_cnt = 0. The rdata registers clear to 0.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request pending: pick the winner, latch its rw/addr/wdata into the RAM output registers, go to ACCESS.
- Arbitration, only one requester pending: grant it.
- Arbitration, both pending and wait_cnt < MAX_WAIT: grant video and increment wait_cnt.
- Arbitration, both pending and wait_cnt == MAX_WAIT: grant CPU.
- wait_cnt clears on any CPU grant. It also clears whenever cpu_req is low in IDLE. wait_cnt saturates and never wraps.
- ACCESS: ram_address is valid.
  - Write: ram_rw = 1 for exactly this one cycle, then go to RESP.
  - Read: ram_rw = 0, load the latency counter with RD_LAT-1, then go to RDWAIT; with RD_LAT = 1, RDWAIT lasts one cycle.
- RDWAIT: count down. When the count reaches 0, capture ram_data_out into the winner's rdata register and go to RESP.
- RESP: pulse the winner's ack for 1 cycle, then go to IDLE. ram_address is held stable from ACCESS through RESP.
- Latency, measured from the IDLE cycle in which req is sampled:
  - Write: ack at cycle +2.
  - Read: ack at cycle +2+RD_LAT.
  - Minimum issue interval: 3 clocks for writes, 3+RD_LAT clocks for reads.
- Handshake rules:
  - The requester holds req, rw, addr and wdata stable until it samples ack high.
  - It drops req (or presents a new request) on that edge.
  - The arbiter never samples req outside IDLE, so a request raised mid-transaction waits.
- rdata holds its value after ack until the next read completion for that port. Write completions do not disturb rdata.
- The loser's ack stays 0. Exactly one ack is asserted per transaction, never both.
- Reset asserted mid-transaction: abort on that edge. No ack is issued, ram_rw = 0 on the next cycle, and the FSM returns to IDLE.
- Requests arriving on the same cycle as reset deassertion are ignored that cycle.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum (IDLE/ACCESS/RDWAIT/RESP);
  - requester IDs (REQ_CPU = 1'b1, REQ_VID = 1'b0);
  - RW encoding constants (RW_WRITE = 1, RW_READ = 0).
- Sub-module ram_arb_pick: combinational winner selection from cpu_req, vid_req and wait_cnt, plus the wait_cnt next-value logic.
- The top level holds the FSM, the RAM output registers and the rdata registers.

Test Plan:
- Lone CPU write: cpu_req with rw = 1, addr 0x0010, wdata 0xBEEF at t0.
  - Required: ram_rw = 1 only at t1 with address 0x0010 and data 0xBEEF; cpu_ack at t2; vid_ack stays 0.
- CPU read-back, RD_LAT = 1: read of 0x0010 at t0.
  - Required: ram_address = 0x0010 at t1..t3; cpu_ack at t3; cpu_rdata = 0xBEEF; ram_rw never asserted.
- Simultaneous requests: both requesters raise req in the same IDLE cycle.
  - Required: video is acked first; the CPU is granted in the next IDLE; wait_cnt = 1 after the video grant and 0 after the CPU grant.
- Starvation guard, MAX_WAIT = 4: video requests back-to-back continuously while cpu_req is held high.
  - Required: exactly 4 vid_acks, then a cpu_ack, then video resumes.
- Reset mid-read, RD_LAT = 3: assert reset during RDWAIT.
  - Required: no ack is ever produced; all outputs are 0 the cycle after reset; the next request completes normally.
- Video write then read: write 0x0123 to 0x2000, then read 0x2000.
  - Required: vid_rdata = 0x0123; cpu_rdata is unchanged from its previous value.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the RAM port arbiter:
//   - arb_state_e : access sequencer states (IDLE/ACCESS/RDWAIT/RESP)
//   - REQ_CPU / REQ_VID : requester IDs, as stored in the grant register
//   - RW_WRITE / RW_READ : rw pin encoding used by both requesters and the RAM
//   - WAIT_W / LAT_W : widths of the starvation and read-latency counters
// ----------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic REQ_CPU  = 1'b1;
    localparam logic REQ_VID  = 1'b0;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Starvation counter covers MAX_WAIT up to 15.
    localparam int WAIT_W = 4;
    // Read-latency down-counter holds RD_LAT-1 for RD_LAT up to 4.
    localparam int LAT_W  = 2;

endpackage

// File: rtl/ram_arb_pick.sv
// ----------------------------------------------------------------------------
// ram_arb_pick
// Combinational winner selection between CPU and video requesters, plus the
// next value of the CPU starvation counter.
// Ports:
//   idle_i       : sequencer is in IDLE (the only state in which requests count)
//   cpu_req_i    : CPU request pending
//   vid_req_i    : video request pending
//   wait_cnt_i   : consecutive video grants while the CPU was also waiting
//   any_req_o    : at least one request is pending
//   winner_o     : REQ_CPU or REQ_VID
//   wait_cnt_d_o : next value of the starvation counter
// ----------------------------------------------------------------------------
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              idle_i,
    input  logic              cpu_req_i,
    input  logic              vid_req_i,
    input  logic [WAIT_W-1:0] wait_cnt_i,
    output logic              any_req_o,
    output logic              winner_o,
    output logic [WAIT_W-1:0] wait_cnt_d_o
);

    logic cpu_forced;

    // Once video has won MAX_WAIT times in a row against a waiting CPU,
    // the CPU takes the next grant.
    assign cpu_forced = (wait_cnt_i >= WAIT_W'(MAX_WAIT));
    assign any_req_o  = cpu_req_i | vid_req_i;

    always_comb begin
        winner_o = REQ_VID;
        if (cpu_req_i && vid_req_i) begin
            winner_o = cpu_forced ? REQ_CPU : REQ_VID;
        end else if (cpu_req_i) begin
            winner_o = REQ_CPU;
        end
    end

    // The counter only moves in IDLE. It increments only when video beats a
    // waiting CPU, which cannot happen once it has reached MAX_WAIT, so it
    // saturates without wrapping.
    always_comb begin
        wait_cnt_d_o = wait_cnt_i;
        if (idle_i) begin
            if (!cpu_req_i || (winner_o == REQ_CPU)) begin
                wait_cnt_d_o = '0;
            end else if (vid_req_i && !cpu_forced) begin
                wait_cnt_d_o = wait_cnt_i + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Shares a single-port RAM between the CPU (port A) and the video text-buffer
// engine (port B). Each access runs IDLE -> ACCESS -> [RDWAIT] -> RESP.
// Video has fixed priority; a CPU that has lost MAX_WAIT grants in a row is
// forced through on the next arbitration.
// Ports:
//   clock, reset               : RAM-domain clock, synchronous active-high reset
//   cpu_req/rw/addr/wdata      : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata         : CPU completion pulse and read data
//   vid_req/rw/addr/wdata      : video request, same handshake as the CPU
//   vid_ack, vid_rdata         : video completion pulse and read data
//   ram_address, ram_data_in   : registered RAM address / write data
//   ram_rw                     : RAM write strobe, high for the one ACCESS cycle
//   ram_data_out               : RAM read data
//   busy                       : sequencer is not in IDLE
//   grant_cpu                  : current or most recent grant went to the CPU
// ----------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic              vid_rw,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [DATA_W-1:0] vid_wdata,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic              grant_cpu
);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              grant_q;
    logic              rw_q;
    logic              ram_rw_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    logic              any_req;
    logic              winner;
    logic              load;
    logic              capture;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    ram_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .idle_i       (state_q == IDLE),
        .cpu_req_i    (cpu_req),
        .vid_req_i    (vid_req),
        .wait_cnt_i   (wait_cnt_q),
        .any_req_o    (any_req),
        .winner_o     (winner),
        .wait_cnt_d_o (wait_cnt_d)
    );

    assign sel_rw    = (winner == REQ_CPU) ? cpu_rw    : vid_rw;
    assign sel_addr  = (winner == REQ_CPU) ? cpu_addr  : vid_addr;
    assign sel_wdata = (winner == REQ_CPU) ? cpu_wdata : vid_wdata;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (rw_q == RW_WRITE) begin
                    state_d = RESP;
                end else begin
                    lat_d   = LAT_W'(RD_LAT - 1);
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                if (lat_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset clears data registers too so every output reads 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            lat_q       <= '0;
            grant_q     <= 1'b0;
            rw_q        <= RW_READ;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lat_q      <= lat_d;
            // The strobe is raised only on the IDLE->ACCESS edge, so it is
            // high for exactly the ACCESS cycle.
            ram_rw_q   <= load && (sel_rw == RW_WRITE);
            if (load) begin
                grant_q     <= winner;
                rw_q        <= sel_rw;
                ram_addr_q  <= sel_addr;
                ram_wdata_q <= sel_wdata;
            end
            if (capture) begin
                if (grant_q == REQ_CPU) begin
                    cpu_rdata_q <= ram_data_out;
                end else begin
                    vid_rdata_q <= ram_data_out;
                end
            end
        end
    end

    assign cpu_ack     = (state_q == RESP) && (grant_q == REQ_CPU);
    assign vid_ack     = (state_q == RESP) && (grant_q == REQ_VID);
    assign cpu_rdata   = cpu_rdata_q;
    assign vid_rdata   = vid_rdata_q;
    assign ram_address = ram_addr_q;
    assign ram_data_in = ram_wdata_q;
    assign ram_rw      = ram_rw_q;
    assign busy        = (state_q != IDLE);
    assign grant_cpu   = grant_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter. Two instances share the requester
// inputs: dut uses RD_LAT = 1, dut3 uses RD_LAT = 3. Each has its own RAM
// model whose read data appears RD_LAT clocks after the address.
// ----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_rw = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        vid_req = 1'b0, vid_rw = 1'b0;
    logic [15:0] vid_addr = '0, vid_wdata = '0;

    logic        cpu_ack, vid_ack, ram_rw, busy, grant_cpu;
    logic [15:0] cpu_rdata, vid_rdata, ram_address, ram_data_in, ram_data_out;

    logic        cpu_ack_3, vid_ack_3, ram_rw_3, busy_3, grant_cpu_3;
    logic [15:0] cpu_rdata_3, vid_rdata_3, ram_address_3, ram_data_in_3, ram_data_out_3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_rw(vid_rw), .vid_addr(vid_addr), .vid_wdata(vid_wdata),
        .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_rw(ram_rw),
        .ram_data_out(ram_data_out), .busy(busy), .grant_cpu(grant_cpu)
    );

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .MAX_WAIT(4)) dut3 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_3), .cpu_rdata(cpu_rdata_3),
        .vid_req(vid_req), .vid_rw(vid_rw), .vid_addr(vid_addr), .vid_wdata(vid_wdata),
        .vid_ack(vid_ack_3), .vid_rdata(vid_rdata_3),
        .ram_address(ram_address_3), .ram_data_in(ram_data_in_3), .ram_rw(ram_rw_3),
        .ram_data_out(ram_data_out_3), .busy(busy_3), .grant_cpu(grant_cpu_3)
    );

    // RAM models
    logic [15:0] mem1 [0:65535];
    logic [15:0] pipe1;
    logic [15:0] mem3 [0:65535];
    logic [15:0] pipe3 [0:2];

    always @(posedge clock) begin
        if (ram_rw) mem1[ram_address] <= ram_data_in;
        pipe1 <= mem1[ram_address];
    end
    assign ram_data_out = pipe1;

    always @(posedge clock) begin
        if (ram_rw_3) mem3[ram_address_3] <= ram_data_in_3;
        pipe3[0] <= mem3[ram_address_3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_data_out_3 = pipe3[2];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({cpu_ack, vid_ack, ram_rw, busy, grant_cpu} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 00000", {cpu_ack, vid_ack, ram_rw, busy, grant_cpu});
        end
        n_cmp++;
        if ({ram_address, ram_data_in} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_ram_bus got %h want 00000000", {ram_address, ram_data_in});
        end
        n_cmp++;
        if ({cpu_rdata, vid_rdata} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata got %h want 00000000", {cpu_rdata, vid_rdata});
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_cpu_write;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        tick(); // t1
        n_cmp++;
        if ({ram_rw, ram_address, ram_data_in} !== {1'b1, 16'h0010, 16'hBEEF}) begin
            n_err++;
            $display("FAIL wr_access got rw=%b a=%h d=%h want rw=1 a=0010 d=beef", ram_rw, ram_address, ram_data_in);
        end
        n_cmp++;
        if ({cpu_ack, vid_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL wr_early_ack got %b want 00", {cpu_ack, vid_ack});
        end
        tick(); // t2
        n_cmp++;
        if ({cpu_ack, vid_ack, ram_rw, grant_cpu} !== 4'b1001) begin
            n_err++;
            $display("FAIL wr_resp got ack/vack/rw/g=%b want 1001", {cpu_ack, vid_ack, ram_rw, grant_cpu});
        end
        cpu_req = 1'b0;
        tick(); // t3
        n_cmp++;
        if ({busy, cpu_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL wr_back_idle got busy/ack=%b want 00", {busy, cpu_ack});
        end
    endtask

    task automatic test_cpu_read;
        logic rw_seen;
        rw_seen = 1'b0;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            rw_seen = rw_seen | ram_rw;
            n_cmp++;
            if (ram_address !== 16'h0010) begin
                n_err++;
                $display("FAIL rd_addr_t%0d got %h want 0010", c, ram_address);
            end
            n_cmp++;
            if (cpu_ack !== (c == 3)) begin
                n_err++;
                $display("FAIL rd_ack_t%0d got %b want %b", c, cpu_ack, (c == 3));
            end
        end
        n_cmp++;
        if (cpu_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rd_data got %h want beef", cpu_rdata);
        end
        n_cmp++;
        if (rw_seen !== 1'b0) begin
            n_err++;
            $display("FAIL rd_no_strobe got %b want 0", rw_seen);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous;
        vid_req = 1'b1; vid_rw = 1'b1; vid_addr = 16'h0040; vid_wdata = 16'h5555;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'hAAAA;
        tick(); // t1
        n_cmp++;
        if ({grant_cpu, ram_address, dut.wait_cnt_q} !== {1'b0, 16'h0040, 4'd1}) begin
            n_err++;
            $display("FAIL sim_vid_grant got g=%b a=%h wc=%0d want g=0 a=0040 wc=1", grant_cpu, ram_address, dut.wait_cnt_q);
        end
        tick(); // t2
        n_cmp++;
        if ({vid_ack, cpu_ack} !== 2'b10) begin
            n_err++;
            $display("FAIL sim_vid_first got vack/cack=%b want 10", {vid_ack, cpu_ack});
        end
        vid_req = 1'b0;
        tick(); // t3 IDLE
        tick(); // t4
        n_cmp++;
        if ({grant_cpu, ram_address, ram_data_in, dut.wait_cnt_q} !== {1'b1, 16'h0050, 16'hAAAA, 4'd0}) begin
            n_err++;
            $display("FAIL sim_cpu_grant got g=%b a=%h d=%h wc=%0d want g=1 a=0050 d=aaaa wc=0", grant_cpu, ram_address, ram_data_in, dut.wait_cnt_q);
        end
        tick(); // t5
        n_cmp++;
        if ({cpu_ack, vid_ack} !== 2'b10) begin
            n_err++;
            $display("FAIL sim_cpu_second got cack/vack=%b want 10", {cpu_ack, vid_ack});
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        logic [5:0] order;
        int         n_acks;
        logic       both;
        order = '0; n_acks = 0; both = 1'b0;
        vid_req = 1'b1; vid_rw = 1'b1; vid_addr = 16'h0100; vid_wdata = 16'h1111;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'h2222;
        for (int c = 0; c < 60 && n_acks < 6; c++) begin
            tick();
            if (cpu_ack && vid_ack) both = 1'b1;
            if (vid_ack) begin
                order[n_acks] = 1'b0;
                n_acks++;
            end else if (cpu_ack) begin
                order[n_acks] = 1'b1;
                n_acks++;
                cpu_req = 1'b0;
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        n_cmp++;
        if (n_acks != 6) begin
            n_err++;
            $display("FAIL starve_ack_count got %0d want 6", n_acks);
        end
        n_cmp++;
        if (order !== 6'b010000) begin
            n_err++;
            $display("FAIL starve_order got %b want 010000 (bit i = ack i, 1 = cpu)", order);
        end
        n_cmp++;
        if (both !== 1'b0) begin
            n_err++;
            $display("FAIL starve_dual_ack got %b want 0", both);
        end
        tick();
    endtask

    task automatic test_vid_write_read;
        int lat;
        vid_req = 1'b1; vid_rw = 1'b1; vid_addr = 16'h2000; vid_wdata = 16'h0123;
        lat = 0;
        do begin tick(); lat++; end while (!vid_ack && lat < 10);
        n_cmp++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL vwr_latency got %0d want 2", lat);
        end
        vid_req = 1'b0;
        tick();
        n_cmp++;
        if (vid_rdata !== 16'h0000) begin
            n_err++;
            $display("FAIL vwr_rdata_kept got %h want 0000", vid_rdata);
        end
        vid_req = 1'b1; vid_rw = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!vid_ack && lat < 10);
        n_cmp++;
        if (lat != 3) begin
            n_err++;
            $display("FAIL vrd_latency got %0d want 3", lat);
        end
        n_cmp++;
        if ({vid_rdata, cpu_rdata} !== {16'h0123, 16'hBEEF}) begin
            n_err++;
            $display("FAIL vrd_data got v=%h c=%h want v=0123 c=beef", vid_rdata, cpu_rdata);
        end
        vid_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read;
        logic seen;
        int   lat;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
        seen = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            seen = seen | cpu_ack_3 | vid_ack_3;
        end
        n_cmp++;
        if (busy_3 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_busy got %b want 1", busy_3);
        end
        reset = 1'b1; // asserted during RDWAIT
        tick();
        n_cmp++;
        if ({cpu_ack_3, vid_ack_3, ram_rw_3, busy_3, grant_cpu_3} !== 5'b0) begin
            n_err++;
            $display("FAIL rst_mid_ctrl got %b want 00000", {cpu_ack_3, vid_ack_3, ram_rw_3, busy_3, grant_cpu_3});
        end
        n_cmp++;
        if ({ram_address_3, ram_data_in_3, cpu_rdata_3, vid_rdata_3} !== 64'h0) begin
            n_err++;
            $display("FAIL rst_mid_data got %h want 0", {ram_address_3, ram_data_in_3, cpu_rdata_3, vid_rdata_3});
        end
        reset = 1'b0;
        cpu_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen = seen | cpu_ack_3 | vid_ack_3;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_no_ack got %b want 0", seen);
        end
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'h7777;
        lat = 0;
        do begin tick(); lat++; end while (!cpu_ack_3 && lat < 12);
        n_cmp++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL rst_after_wr_latency got %0d want 2", lat);
        end
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_rw = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!cpu_ack_3 && lat < 12);
        n_cmp++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL rst_after_rd_latency got %0d want 5", lat);
        end
        n_cmp++;
        if (cpu_rdata_3 !== 16'h7777) begin
            n_err++;
            $display("FAIL rst_after_rd_data got %h want 7777", cpu_rdata_3);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_vid_write_read();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
